// File: rtl/cmd_dispatcher_if.sv
// Command dispatcher bus: UART rx byte in, per-channel activate/done, shared tx request, status out.
// Dispatcher takes the slave side; the surrounding system (UART, function blocks) takes the master side.
interface cmd_dispatcher_if #(
    parameter int NUM_CMDS  = 8,
    parameter int CMD_WIDTH = 8
);
    logic                 rx_ready;
    logic [CMD_WIDTH-1:0] rx_data;
    logic [NUM_CMDS-1:0]  activate;
    logic [NUM_CMDS-1:0]  done;
    logic                 tx_own;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_active;
    logic                 tx_done;
    logic                 busy;
    logic [CMD_WIDTH-1:0] state_code;

    modport master (
        output rx_ready, rx_data, done, tx_active, tx_done,
        input  activate, tx_own, tx_start, tx_data, busy, state_code
    );

    modport slave (
        input  rx_ready, rx_data, done, tx_active, tx_done,
        output activate, tx_own, tx_start, tx_data, busy, state_code
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// Decodes a UART command byte into a one-hot channel activate, then reports a status byte over the shared tx.
// rx->activate 1 cycle, done->tx_start 2 cycles; tx_start is held back while tx_active, rx bytes dropped while reporting.
module cmd_dispatcher #(
    parameter int                          NUM_CMDS       = 8,
    parameter int                          CMD_WIDTH      = 8,
    parameter logic [NUM_CMDS*CMD_WIDTH-1:0] CMD_TABLE    = {8'h11, 8'h21, 8'h22, 8'h71,
                                                             8'h72, 8'h00, 8'h00, 8'h00},
    parameter logic [CMD_WIDTH-1:0]        ABORT_CODE     = 8'h1B,
    parameter int                          TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]                  ACK_BYTE       = 8'h06,
    parameter logic [7:0]                  NAK_BYTE       = 8'h15,
    parameter logic [7:0]                  ABT_BYTE       = 8'h18,
    parameter logic [7:0]                  TMO_BYTE       = 8'h14
) (
    input  logic            clk,
    input  logic            reset,
    cmd_dispatcher_if.slave bus
);
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ACTIVE      = 2'd1;
    localparam logic [1:0] ST_REPORT_WAIT = 2'd2;
    localparam logic [1:0] ST_REPORT_TX   = 2'd3;

    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]           state_q;
    logic [NUM_CMDS-1:0]  activate_q;
    logic [CMD_WIDTH-1:0] state_code_q;
    logic                 busy_q;
    logic                 tx_own_q;
    logic                 tx_start_q;
    logic [7:0]           tx_data_q;
    logic [7:0]           status_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 match_hit;
    logic [NUM_CMDS-1:0]  match_onehot;
    logic                 finish;
    logic [7:0]           finish_status;

    // Table entry 0 lives in the MSB slice; scanning downward lets the lowest index win on duplicates.
    always_comb begin
        match_hit    = 1'b0;
        match_onehot = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (CMD_TABLE[(NUM_CMDS-1-i)*CMD_WIDTH +: CMD_WIDTH] != '0 &&
                CMD_TABLE[(NUM_CMDS-1-i)*CMD_WIDTH +: CMD_WIDTH] == bus.rx_data) begin
                match_hit       = 1'b1;
                match_onehot    = '0;
                match_onehot[i] = 1'b1;
            end
        end
    end

    // Termination priority while a channel runs: its own done, then watchdog, then abort byte.
    always_comb begin
        finish        = 1'b1;
        finish_status = ACK_BYTE;
        if (|(activate_q & bus.done)) begin
            finish_status = ACK_BYTE;
        end else if (WDOG_EN && cnt_q == CNT_LAST) begin
            finish_status = TMO_BYTE;
        end else if (bus.rx_ready && bus.rx_data == ABORT_CODE) begin
            finish_status = ABT_BYTE;
        end else begin
            finish = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            activate_q   <= '0;
            state_code_q <= '0;
            busy_q       <= 1'b0;
            tx_own_q     <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            status_q     <= '0;
            cnt_q        <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_ready) begin
                        busy_q <= 1'b1;
                        if (match_hit) begin
                            activate_q   <= match_onehot;
                            state_code_q <= bus.rx_data;
                            cnt_q        <= '0;
                            state_q      <= ST_ACTIVE;
                        end else begin
                            status_q <= NAK_BYTE;
                            tx_own_q <= 1'b1;
                            state_q  <= ST_REPORT_WAIT;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (finish) begin
                        activate_q   <= '0;
                        state_code_q <= '0;
                        status_q     <= finish_status;
                        tx_own_q     <= 1'b1;
                        state_q      <= ST_REPORT_WAIT;
                    end
                end
                ST_REPORT_WAIT: begin
                    if (!bus.tx_active) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= status_q;
                        state_q    <= ST_REPORT_TX;
                    end
                end
                default: begin
                    if (bus.tx_done) begin
                        tx_own_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.activate   = activate_q;
    assign bus.state_code = state_code_q;
    assign bus.busy       = busy_q;
    assign bus.tx_own     = tx_own_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: vector table of commands plus hand-written sequences for tx backpressure and reset.
module tb_cmd_dispatcher;
    localparam int K_NAK = 0, K_DONE = 1, K_ABORT = 2, K_TMO = 3, K_BOTH = 4;

    typedef struct {
        logic [7:0] cmd;
        int         kind;
        int         delay;
        int         ch;
        logic [7:0] exp_act;
        logic [7:0] exp_code;
        logic [7:0] exp_stat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic tx_busy;
    logic hold_busy;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[9];

    cmd_dispatcher_if #(.NUM_CMDS(8), .CMD_WIDTH(8)) bus ();

    cmd_dispatcher #(.TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.tx_active = tx_busy | hold_busy;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
        end
        chk({name, " back to idle"}, 32'(bus.busy), 32'd0);
        chk({name, " tx_own released"}, 32'(bus.tx_own), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " activate"}, 32'(bus.activate), 32'd0);
        chk({name, " tx_own"}, 32'(bus.tx_own), 32'd0);
        chk({name, " tx_start"}, 32'(bus.tx_start), 32'd0);
        chk({name, " tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({name, " busy"}, 32'(bus.busy), 32'd0);
        chk({name, " state_code"}, 32'(bus.state_code), 32'd0);
    endtask

    // Transmitter model: busy for a few cycles after each tx_start, then a tx_done pulse.
    initial begin
        tx_busy     = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            tick();
            if (bus.tx_start) begin
                tx_busy = 1'b1;
                repeat (3) tick();
                bus.tx_done = 1'b1;
                tx_busy     = 1'b0;
                tick();
                bus.tx_done = 1'b0;
            end
        end
    end

    // Scoreboard consumer and structural invariants, evaluated every cycle.
    initial begin
        logic [7:0] exp;
        forever begin
            tick();
            chk("activate one-hot", 32'($onehot0(bus.activate)), 32'd1);
            chk("tx_own with activate", 32'(bus.tx_own && (|bus.activate)), 32'd0);
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected tx_start: got %02h required no transmission", bus.tx_data);
                end else begin
                    exp = exp_q.pop_front();
                    chk("status byte", 32'(bus.tx_data), 32'(exp));
                end
                chk("tx_own at tx_start", 32'(bus.tx_own), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global time limit: got still running required finished");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{8'h21, K_DONE,  10, 1, 8'h02, 8'h21, 8'h06};
        vecs[1] = '{8'h55, K_NAK,    0, 0, 8'h00, 8'h00, 8'h15};
        vecs[2] = '{8'h00, K_NAK,    0, 0, 8'h00, 8'h00, 8'h15};
        vecs[3] = '{8'h1B, K_NAK,    0, 0, 8'h00, 8'h00, 8'h15};
        vecs[4] = '{8'h71, K_TMO,    0, 3, 8'h08, 8'h71, 8'h14};
        vecs[5] = '{8'h72, K_ABORT,  5, 4, 8'h10, 8'h72, 8'h18};
        vecs[6] = '{8'h72, K_BOTH,   3, 4, 8'h10, 8'h72, 8'h06};
        vecs[7] = '{8'h11, K_DONE,   0, 0, 8'h01, 8'h11, 8'h06};
        vecs[8] = '{8'h22, K_DONE,   2, 2, 8'h04, 8'h22, 8'h06};

        reset        = 1'b0;
        hold_busy    = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.done     = '0;
        repeat (3) tick();
        chk_all_zero("in reset");
        reset = 1'b1;
        repeat (2) tick();
        chk_all_zero("after release");

        foreach (vecs[v]) begin
            string nm;
            nm = $sformatf("vec%0d cmd %02h", v, vecs[v].cmd);
            send_byte(vecs[v].cmd);
            chk({nm, " activate"}, 32'(bus.activate), 32'(vecs[v].exp_act));
            chk({nm, " state_code"}, 32'(bus.state_code), 32'(vecs[v].exp_code));
            chk({nm, " busy"}, 32'(bus.busy), 32'd1);
            exp_q.push_back(vecs[v].exp_stat);
            case (vecs[v].kind)
                K_NAK: chk({nm, " tx_own"}, 32'(bus.tx_own), 32'd1);
                K_TMO: begin
                    int n = 0;
                    while (bus.activate != '0 && n < 1000) begin
                        n++;
                        tick();
                    end
                    chk({nm, " activate high cycles"}, 32'(n), 32'd100);
                end
                default: begin
                    repeat (vecs[v].delay) tick();
                    chk({nm, " activate held"}, 32'(bus.activate), 32'(vecs[v].exp_act));
                    if (vecs[v].kind != K_ABORT) bus.done[vecs[v].ch] = 1'b1;
                    if (vecs[v].kind != K_DONE) begin
                        bus.rx_ready = 1'b1;
                        bus.rx_data  = 8'h1B;
                    end
                    tick();
                    bus.done     = '0;
                    bus.rx_ready = 1'b0;
                    bus.rx_data  = 8'h00;
                    chk({nm, " activate dropped"}, 32'(bus.activate), 32'd0);
                    chk({nm, " state_code cleared"}, 32'(bus.state_code), 32'd0);
                    tick();
                    chk({nm, " tx_start latency"}, 32'(bus.tx_start), 32'd1);
                    tick();
                    chk({nm, " tx_start single pulse"}, 32'(bus.tx_start), 32'd0);
                end
            endcase
            wait_idle(nm);
        end

        // Foreign done, in-ACTIVE command byte, then a long tx_active hold in REPORT_WAIT.
        send_byte(8'h11);
        exp_q.push_back(8'h06);
        repeat (2) tick();
        bus.done = 8'h04;
        tick();
        bus.done = '0;
        chk("foreign done ignored", 32'(bus.activate), 32'h01);
        send_byte(8'h21);
        chk("rx in ACTIVE ignored activate", 32'(bus.activate), 32'h01);
        chk("rx in ACTIVE ignored state_code", 32'(bus.state_code), 32'h11);
        hold_busy = 1'b1;
        bus.done  = 8'h01;
        tick();
        bus.done = '0;
        chk("hold activate dropped", 32'(bus.activate), 32'd0);
        for (int i = 0; i < 50; i++) begin
            bus.rx_ready = (i == 10);
            bus.rx_data  = (i == 10) ? 8'h21 : 8'h00;
            tick();
            chk("hold tx_start withheld", 32'(bus.tx_start), 32'd0);
            chk("hold tx_own", 32'(bus.tx_own), 32'd1);
            chk("hold rx dropped", 32'(bus.activate), 32'd0);
        end
        bus.rx_ready = 1'b0;
        hold_busy    = 1'b0;
        tick();
        chk("tx_start after tx_active falls", 32'(bus.tx_start), 32'd1);
        wait_idle("hold");

        // Asynchronous reset in the middle of ACTIVE.
        send_byte(8'h72);
        repeat (3) tick();
        #3 reset = 1'b0;
        #1 chk_all_zero("reset mid-ACTIVE");
        tick();
        #2 reset = 1'b1;
        tick();
        send_byte(8'h11);
        chk("post-reset dispatch", 32'(bus.activate), 32'h01);
        exp_q.push_back(8'h06);
        bus.done = 8'h01;
        tick();
        bus.done = '0;
        wait_idle("post-reset A");

        // Asynchronous reset in the middle of REPORT_TX.
        send_byte(8'h55);
        exp_q.push_back(8'h15);
        tick();
        chk("nak tx_start", 32'(bus.tx_start), 32'd1);
        tick();
        #3 reset = 1'b0;
        #1 chk_all_zero("reset mid-REPORT_TX");
        tick();
        #2 reset = 1'b1;
        repeat (6) tick();
        send_byte(8'h11);
        chk("post-reset dispatch 2", 32'(bus.activate), 32'h01);
        chk("post-reset state_code", 32'(bus.state_code), 32'h11);
        exp_q.push_back(8'h06);
        bus.done = 8'h01;
        tick();
        bus.done = '0;
        wait_idle("post-reset B");

        repeat (2) tick();
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
